// File: rtl/uart_msg_sequencer_pkg.sv
// Shared definitions for the UART message sequencer.
//   - FSM state encoding (3-bit) used by the sequencer controller.
//   - TX_IDLE: transmitter state value meaning "no frame in progress".
package uart_msg_sequencer_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARB   = 3'd1;
  localparam logic [2:0] ST_FETCH = 3'd2;
  localparam logic [2:0] ST_LOAD  = 3'd3;
  localparam logic [2:0] ST_START = 3'd4;
  localparam logic [2:0] ST_WAIT  = 3'd5;
  localparam logic [2:0] ST_NEXT  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ARB   = ST_ARB,
    S_FETCH = ST_FETCH,
    S_LOAD  = ST_LOAD,
    S_START = ST_START,
    S_WAIT  = ST_WAIT,
    S_NEXT  = ST_NEXT
  } state_t;

  localparam logic [1:0] TX_IDLE = 2'b00;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : pending request per requester
//   ptr       : highest-priority requester this round
//   grant     : one-hot winner (all zero when nothing is pending)
//   grant_idx : encoded winner index (0 when nothing is pending)
// The priority pointer register lives in the caller.
module uart_rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_idx
);

  // Scan from ptr upward, wrapping modulo N_REQ; first set bit wins.
  always_comb begin
    logic found;
    int   j;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req[IW'(j)]) begin
        found            = 1'b1;
        grant[IW'(j)]    = 1'b1;
        grant_idx        = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_msg_sequencer.sv
// Shares one UART transmitter among N_REQ requesters, each asking for a
// stored message (base address + length) in a synchronous message ROM.
//   CLK, RST          : clock, asynchronous active-high reset
//   req               : level request per requester, held until its done
//   msg_base, msg_len : packed per-requester base address / byte count
//   gnt, done         : one-hot single-cycle accept / completion pulses
//   busy              : high from the grant cycle through the done cycle
//   rom_addr, rom_data: ROM port, data valid one cycle after the address
//   tx_start, tx_data : transmitter handshake and byte (stable per frame)
//   tx_state          : transmitter state, TX_IDLE when no frame running
module uart_msg_sequencer #(
  parameter int N_REQ = 4,
  parameter int WL    = 8,
  parameter int AW    = 6,
  parameter int LEN_W = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*AW-1:0]    msg_base,
  input  logic [N_REQ*LEN_W-1:0] msg_len,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [AW-1:0]          rom_addr,
  input  logic [WL-1:0]          rom_data,
  output logic                   tx_start,
  output logic [WL-1:0]          tx_data,
  input  logic [1:0]             tx_state
);
  import uart_msg_sequencer_pkg::*;

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t state, state_next;

  logic [IW-1:0]    ptr;
  logic [N_REQ-1:0] owner;
  logic [AW-1:0]    base_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx;
  logic [LEN_W-1:0] idx_inc;
  logic             armed;

  logic [N_REQ-1:0] arb_grant;
  logic [IW-1:0]    arb_idx;
  logic [AW-1:0]    sel_base;
  logic [LEN_W-1:0] sel_len;
  logic             any_req;
  logic             tx_idle;
  logic             last_byte;

  uart_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (req),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // Pick the winner's base and length out of the packed request fields.
  always_comb begin
    sel_base = '0;
    sel_len  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_idx == IW'(i)) begin
        sel_base = msg_base[i*AW +: AW];
        sel_len  = msg_len[i*LEN_W +: LEN_W];
      end
    end
  end

  assign any_req   = |req;
  assign tx_idle   = (tx_state == TX_IDLE);
  assign idx_inc   = idx + LEN_W'(1);
  assign last_byte = (idx == len_q - LEN_W'(1));

  // The done cycle is spent back in IDLE, so busy also covers a live done pulse.
  assign busy = ((state != S_IDLE) && (state != S_ARB)) ||
                ((state == S_ARB) && any_req) ||
                (|done);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; gnt and tx_start are Mealy outputs so tx_start can drop
  // in the very cycle the transmitter is seen leaving idle.
  always_comb begin
    state_next = state;
    gnt        = '0;
    tx_start   = 1'b0;
    unique case (state)
      S_IDLE:  if (any_req) state_next = S_ARB;
      S_ARB: begin
        if (any_req) begin
          gnt        = arb_grant;
          state_next = (sel_len == '0) ? S_IDLE : S_FETCH;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_FETCH: state_next = S_LOAD;
      S_LOAD:  state_next = S_START;
      S_START: begin
        // Before arming, a non-idle transmitter is someone else's frame.
        if (!armed)       tx_start   = tx_idle;
        else if (tx_idle) tx_start   = 1'b1;
        else              state_next = S_WAIT;
      end
      S_WAIT:  if (tx_idle) state_next = S_NEXT;
      S_NEXT:  state_next = last_byte ? S_IDLE : S_FETCH;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath. rom_addr is updated on the way into FETCH so the synchronous
  // ROM sees it during FETCH and its data is ready for the LOAD capture.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr      <= '0;
      owner    <= '0;
      base_q   <= '0;
      len_q    <= '0;
      idx      <= '0;
      armed    <= 1'b0;
      rom_addr <= '0;
      tx_data  <= '0;
      done     <= '0;
    end else begin
      done <= '0;
      case (state)
        S_ARB: begin
          if (any_req) begin
            owner  <= arb_grant;
            base_q <= sel_base;
            len_q  <= sel_len;
            idx    <= '0;
            ptr    <= (arb_idx == IW'(N_REQ-1)) ? '0 : arb_idx + IW'(1);
            if (sel_len == '0) done     <= arb_grant;
            else               rom_addr <= sel_base;
          end
        end
        S_LOAD:  tx_data <= rom_data;
        S_START: begin
          if (!armed && tx_idle)      armed <= 1'b1;
          else if (armed && !tx_idle) armed <= 1'b0;
        end
        S_NEXT: begin
          if (last_byte) begin
            done <= owner;
          end else begin
            idx      <= idx_inc;
            rom_addr <= base_q + AW'(idx_inc);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// Self-checking bench for uart_msg_sequencer: synchronous ROM model,
// transmitter model with configurable start delay, passive monitor, and a
// message-level reference model (round-robin pick + ROM byte lists).
module tb_uart_msg_sequencer;

  localparam int N_REQ = 4, WL = 8, AW = 6, LEN_W = 6;

  logic                   CLK = 1'b0;
  logic                   RST = 1'b0;
  logic [N_REQ-1:0]       req = '0;
  logic [N_REQ*AW-1:0]    msg_base = '0;
  logic [N_REQ*LEN_W-1:0] msg_len = '0;
  logic [N_REQ-1:0]       gnt, done;
  logic                   busy, tx_start;
  logic [AW-1:0]          rom_addr;
  logic [WL-1:0]          rom_data = '0;
  logic [WL-1:0]          tx_data;
  logic [1:0]             tx_state = 2'b00;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  uart_msg_sequencer #(.N_REQ(N_REQ), .WL(WL), .AW(AW), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .RST(RST), .req(req), .msg_base(msg_base), .msg_len(msg_len),
    .gnt(gnt), .done(done), .busy(busy), .rom_addr(rom_addr), .rom_data(rom_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_state(tx_state)
  );

  // Synchronous message ROM
  logic [7:0] rom [64];
  always @(posedge CLK) rom_data <= rom[rom_addr];

  // Transmitter model: accepts tx_start after tx_delay extra cycles, then
  // runs a frame of random length with a random non-idle state code.
  int         tx_delay = 0;
  int         wait_cnt = 0;
  int         frame_cnt = 0;
  logic [7:0] cur_byte = '0;
  logic [7:0] acc_byte_q[$];
  logic [5:0] acc_addr_q[$];
  always @(posedge CLK) begin
    if (tx_state == 2'b00) begin
      if (tx_start === 1'b1) begin
        if (wait_cnt >= tx_delay) begin
          tx_state  <= 2'($urandom_range(1, 3));
          frame_cnt <= $urandom_range(2, 5);
          wait_cnt  <= 0;
          cur_byte  <= tx_data;
          acc_byte_q.push_back(tx_data);
          acc_addr_q.push_back(rom_addr);
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end else begin
        wait_cnt <= 0;
      end
    end else if (frame_cnt == 0) begin
      tx_state <= 2'b00;
    end else begin
      frame_cnt <= frame_cnt - 1;
    end
  end

  // Passive monitor, sampling on the falling edge
  int         cyc = 0, start_cnt = 0, run = 0, min_gap = 1000, idle_cyc = -1000;
  int         overlap_err = 0, stab_err = 0, busy_err = 0;
  logic [1:0] prev_txs = 2'b00;
  logic [3:0] gnt_q[$], done_q[$];
  int         gcyc_q[$], dcyc_q[$], run_q[$];
  always @(negedge CLK) begin
    cyc      <= cyc + 1;
    prev_txs <= tx_state;
    if (prev_txs != 2'b00 && tx_state == 2'b00) idle_cyc <= cyc;
    if (gnt != '0) begin
      gnt_q.push_back(gnt); gcyc_q.push_back(cyc);
      if (busy !== 1'b1) busy_err <= busy_err + 1;
    end
    if (done != '0) begin
      done_q.push_back(done); dcyc_q.push_back(cyc);
      if (busy !== 1'b1) busy_err <= busy_err + 1;
    end
    if (tx_start === 1'b1) begin
      start_cnt <= start_cnt + 1;
      run       <= run + 1;
      if (tx_state != 2'b00) overlap_err <= overlap_err + 1;
      if (run == 0 && (cyc - idle_cyc) < min_gap) min_gap <= cyc - idle_cyc;
    end else if (run != 0) begin
      run_q.push_back(run);
      run <= 0;
    end
    if (busy === 1'b1 && tx_state != 2'b00 && tx_data !== cur_byte) stab_err <= stab_err + 1;
  end

  // Reference model state
  int cfg_base[4];
  int cfg_len[4];
  int m_ptr = 0;

  function automatic int rrPick(input logic [3:0] pat, input int p);
    for (int i = 0; i < 4; i++) begin
      if (pat[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] pat, input int delay);
    for (int i = 0; i < 4; i++) begin
      msg_base[i*AW +: AW]       = AW'(cfg_base[i]);
      msg_len[i*LEN_W +: LEN_W]  = LEN_W'(cfg_len[i]);
    end
    tx_delay = delay;
    req      = pat;
  endtask

  // Hold pattern pat until n done pulses, then compare against the model.
  task automatic runRound(input logic [3:0] pat, input int n, input int delay, input string tag);
    int         eg[$];
    logic [7:0] eb[$];
    logic [5:0] ea[$];
    int g0, d0, b0, cnt, cycles, k;
    g0 = gnt_q.size(); d0 = done_q.size(); b0 = acc_byte_q.size();
    for (int m = 0; m < n; m++) begin
      k = rrPick(pat, m_ptr);
      eg.push_back(k);
      m_ptr = (k + 1) % 4;
      for (int i = 0; i < cfg_len[k]; i++) begin
        eb.push_back(rom[(cfg_base[k] + i) % 64]);
        ea.push_back(6'((cfg_base[k] + i) % 64));
      end
    end
    @(posedge CLK); #2;
    applyStimulus(pat, delay);
    cnt = 0; cycles = 0;
    while (cnt < n && cycles < 3000) begin
      @(negedge CLK);
      cycles++;
      if (done != '0) cnt++;
    end
    #1 req = '0;
    checkOutput({tag, "_done_count"}, cnt, n);
    repeat (3) @(negedge CLK);
    checkOutput({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    for (int m = 0; m < n; m++) begin
      checkOutput($sformatf("%s_gnt%0d", tag, m), {28'd0, gnt_q[g0+m]}, 32'd1 << eg[m]);
      checkOutput($sformatf("%s_done%0d", tag, m), {28'd0, done_q[d0+m]}, 32'd1 << eg[m]);
    end
    checkOutput({tag, "_byte_count"}, acc_byte_q.size() - b0, eb.size());
    for (int i = 0; i < eb.size(); i++) begin
      checkOutput($sformatf("%s_byte%0d", tag, i), {24'd0, acc_byte_q[b0+i]}, {24'd0, eb[i]});
      checkOutput($sformatf("%s_addr%0d", tag, i), {26'd0, acc_addr_q[b0+i]}, {26'd0, ea[i]});
    end
  endtask

  initial begin
    int g0, b0, s0, r0, d0, cycles;
    logic hit;
    for (int i = 0; i < 64; i++) rom[i] = 8'($urandom);
    rom[4] = 8'h41; rom[5] = 8'h42; rom[6] = 8'h43;
    for (int i = 0; i < 4; i++) begin cfg_base[i] = 0; cfg_len[i] = 1; end

    // Reset values
    RST = 1'b1;
    repeat (2) @(posedge CLK); #1;
    checkOutput("rst_gnt", {28'd0, gnt}, 32'd0);
    checkOutput("rst_done", {28'd0, done}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_tx_start", {31'd0, tx_start}, 32'd0);
    checkOutput("rst_tx_data", {24'd0, tx_data}, 32'd0);
    checkOutput("rst_rom_addr", {26'd0, rom_addr}, 32'd0);
    @(posedge CLK); #2 RST = 1'b0;
    m_ptr = 0;

    // Round-robin fairness: 0,1,3,0,1,3 with requester 2 idle
    for (int i = 0; i < 4; i++) begin cfg_base[i] = $urandom_range(0, 63); cfg_len[i] = 1; end
    g0 = gnt_q.size();
    runRound(4'b1011, 6, 0, "rr");
    checkOutput("rr_first_is_0", {28'd0, gnt_q[g0]}, 32'h1);
    checkOutput("rr_third_is_3", {28'd0, gnt_q[g0+2]}, 32'h8);

    // Single three-byte message
    cfg_base[0] = 4; cfg_len[0] = 3;
    b0 = acc_byte_q.size(); s0 = start_cnt;
    runRound(4'b0001, 1, 0, "single");
    checkOutput("single_first_byte", {24'd0, acc_byte_q[b0]}, 32'h41);
    checkOutput("single_last_byte", {24'd0, acc_byte_q[b0+2]}, 32'h43);
    checkOutput("single_start_cycles", start_cnt - s0, 3);

    // Zero-length message
    cfg_len[2] = 0;
    g0 = gcyc_q.size(); d0 = dcyc_q.size(); s0 = start_cnt;
    runRound(4'b0100, 1, 0, "zero");
    checkOutput("zero_done_latency", dcyc_q[d0] - gcyc_q[g0], 1);
    checkOutput("zero_no_tx_start", start_cnt - s0, 0);

    // Address wrap
    cfg_base[1] = 6'h3E; cfg_len[1] = 4;
    b0 = acc_addr_q.size();
    runRound(4'b0010, 1, 0, "wrap");
    checkOutput("wrap_addr2", {26'd0, acc_addr_q[b0+2]}, 32'h00);

    // Handshake stall: transmitter waits 5 extra cycles before leaving idle
    cfg_base[0] = $urandom_range(0, 63); cfg_len[0] = 2;
    r0 = run_q.size();
    runRound(4'b0001, 1, 5, "stall");
    checkOutput("stall_run0", run_q[r0], 6);
    checkOutput("stall_run1", run_q[r0+1], 6);

    // Randomized rounds
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        cfg_base[i] = $urandom_range(0, 63);
        cfg_len[i]  = $urandom_range(0, 4);
      end
      runRound(4'($urandom_range(1, 15)), $urandom_range(1, 5), $urandom_range(0, 2),
               $sformatf("rand%0d", r));
    end

    // Reset during byte 2 of a 4-byte message, while tx_start is high
    cfg_base[0] = $urandom_range(0, 63); cfg_len[0] = 4;
    b0 = acc_byte_q.size();
    @(posedge CLK); #2;
    applyStimulus(4'b0001, 3);
    hit = 1'b0; cycles = 0;
    while (!hit && cycles < 2000) begin
      @(negedge CLK);
      cycles++;
      if (acc_byte_q.size() - b0 == 1 && tx_start === 1'b1) hit = 1'b1;
    end
    checkOutput("midrst_reached", {31'd0, hit}, 32'd1);
    d0 = done_q.size();
    #1 RST = 1'b1;
    #1;
    checkOutput("midrst_tx_start", {31'd0, tx_start}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_gnt", {28'd0, gnt}, 32'd0);
    checkOutput("midrst_done", {28'd0, done}, 32'd0);
    checkOutput("midrst_tx_data", {24'd0, tx_data}, 32'd0);
    checkOutput("midrst_rom_addr", {26'd0, rom_addr}, 32'd0);
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0; req = '0;
    repeat (20) @(negedge CLK);
    checkOutput("midrst_no_done", done_q.size(), d0);
    m_ptr = 0;
    for (int i = 0; i < 4; i++) begin cfg_base[i] = $urandom_range(0, 63); cfg_len[i] = $urandom_range(1, 3); end
    runRound(4'b1011, 1, 0, "post_rst");

    // Protocol invariants gathered by the monitor
    checkOutput("tx_start_while_busy", overlap_err, 0);
    checkOutput("tx_data_stable", stab_err, 0);
    checkOutput("busy_cover", busy_err, 0);
    checkOutput("inter_byte_gap_ge3", {31'd0, (min_gap >= 3)}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
